// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on clk: synchronised pins, all four SPI modes, B-bit words,
// and a one-entry TX buffer so words can stream back-to-back within one ss frame.
module spi_slave_sync #(
  parameter int B    = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         ss,
  output logic         miso,
  input  logic [B-1:0] wordin,
  input  logic         load,
  output logic [B-1:0] wordout,
  output logic         br,
  output logic         txe
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int CW = $clog2(B);
  localparam logic [CW-1:0] LAST = CW'(B - 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SHIFT, S_RELOAD} state_t;

  state_t        state, nstate;
  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          ss_s1, ss_s2, ss_s3;
  logic          mosi_s1, mosi_s2;
  logic [1:0]    warm;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [B-1:0]  rx, tx, txbuf;
  logic [B-1:0]  rx_next, src;
  logic          lead, trail, sample_e, shift_e, ss_fall, start;
  logic          do_sample, do_shift, do_reload, do_present;

  assign lead     = (sclk_s2 != CPOL) && (sclk_s3 == CPOL);
  assign trail    = (sclk_s2 == CPOL) && (sclk_s3 != CPOL);
  assign sample_e = CPHA ? trail : lead;
  assign shift_e  = CPHA ? lead : trail;
  assign ss_fall  = !ss_s2 && ss_s3;
  // armed only after the sync chain holds real pin samples and ss was seen high,
  // so an ss held low across reset does not look like a fresh frame start
  assign start    = ss_fall && armed && (state == S_IDLE);
  assign rx_next  = {rx[B-2:0], mosi_s2};
  assign src      = txe ? '0 : txbuf;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate     = state;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    do_reload  = 1'b0;
    do_present = 1'b0;
    if (ss_s2) begin
      nstate = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) nstate = CPHA ? S_FIRST : S_SHIFT;
        end
        S_FIRST: begin
          if (shift_e) begin
            do_present = 1'b1;
            nstate     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          do_sample = sample_e;
          do_shift  = shift_e;
          if (sample_e && (cnt == LAST)) nstate = S_RELOAD;
        end
        S_RELOAD: begin
          if (shift_e) begin
            do_reload = 1'b1;
            nstate    = S_SHIFT;
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_s3 <= CPOL;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      warm    <= '0;
      armed   <= 1'b0;
      cnt     <= '0;
      rx      <= '0;
      tx      <= '0;
      txbuf   <= '0;
      miso    <= 1'b0;
      wordout <= '0;
      br      <= 1'b0;
      txe     <= 1'b1;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && ss_s2) armed <= 1'b1;
      br <= 1'b0;

      if (ss_s2) begin
        cnt  <= '0;
        rx   <= '0;
        miso <= 1'b0;
      end else begin
        if (start) begin
          cnt <= '0;
          rx  <= '0;
          tx  <= src;
          if (!CPHA) miso <= src[B-1];
        end
        if (do_sample) begin
          rx <= rx_next;
          if (cnt == LAST) begin
            wordout <= rx_next;
            br      <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // tx[B-1] always mirrors the bit currently on miso
        if (do_reload) begin
          tx   <= src;
          miso <= src[B-1];
        end else if (do_present) begin
          miso <= tx[B-1];
        end else if (do_shift) begin
          tx   <= {tx[B-2:0], 1'b0};
          miso <= tx[B-2];
        end
      end

      // a reload consumes the old buffer before a same-cycle load refills it
      if (start || do_reload) txe <= 1'b1;
      if (load) begin
        txbuf <= wordin;
        txe   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomised SPI-master bench for spi_slave_sync: three instances (MODE0/B8,
// MODE3/B12, MODE1/B12) checked against a word-level buffer/frame model.
module tb_spi_slave_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  sclk_v, mosi_v, ss_v, load_v;
  logic [11:0] wordin;
  logic        miso0, miso1, miso2, br0, br1, br2, txe0, txe1, txe2;
  logic [7:0]  wordout0;
  logic [11:0] wordout1, wordout2;
  logic [2:0]  miso_v, br_v, txe_v;

  assign miso_v = {miso2, miso1, miso0};
  assign br_v   = {br2, br1, br0};
  assign txe_v  = {txe2, txe1, txe0};

  spi_slave_sync #(.B(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .ss(ss_v[0]),
    .miso(miso0), .wordin(wordin[7:0]), .load(load_v[0]),
    .wordout(wordout0), .br(br0), .txe(txe0));
  spi_slave_sync #(.B(12), .MODE(3)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .ss(ss_v[1]),
    .miso(miso1), .wordin(wordin), .load(load_v[1]),
    .wordout(wordout1), .br(br1), .txe(txe1));
  spi_slave_sync #(.B(12), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .ss(ss_v[2]),
    .miso(miso2), .wordin(wordin), .load(load_v[2]),
    .wordout(wordout2), .br(br2), .txe(txe2));

  int bw[3]   = '{8, 12, 12};
  int mode[3] = '{0, 3, 1};

  int          n_cmp = 0;
  int          n_err = 0;
  int          brcnt[3] = '{0, 0, 0};
  int          m_br[3]  = '{0, 0, 0};
  logic [11:0] m_buf[3];
  logic        m_txe[3];
  logic [11:0] m_wo[3];
  logic [11:0] cur[3];

  always @(negedge clk) begin
    if (br0) brcnt[0]++;
    if (br1) brcnt[1]++;
    if (br2) brcnt[2]++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] get_wo(input int d);
    case (d)
      0:       return {4'h0, wordout0};
      1:       return wordout1;
      default: return wordout2;
    endcase
  endfunction

  function automatic logic [11:0] msk(input int d);
    return 12'((1 << bw[d]) - 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int d, input logic [11:0] w);
    wordin    = w & msk(d);
    load_v[d] = 1'b1;
    tick(1);
    load_v[d] = 1'b0;
    m_buf[d]  = w & msk(d);
    m_txe[d]  = 1'b0;
  endtask

  task automatic consume(input int d);
    cur[d]   = m_txe[d] ? 12'h0 : m_buf[d];
    m_txe[d] = 1'b1;
  endtask

  task automatic ss_low(input int d);
    consume(d);
    ss_v[d] = 1'b0;
    tick(6);
    check("txe_at_frame_start", txe_v[d], 1);
  endtask

  task automatic ss_high(input int d);
    tick(4);
    ss_v[d] = 1'b1;
    tick(6);
    check("miso_idle", miso_v[d], 0);
    check("txe_after_frame", txe_v[d], m_txe[d]);
    check("br_count", brcnt[d], m_br[d]);
    check("wordout_hold", get_wo(d), m_wo[d]);
  endtask

  // master drives nbits of w MSB first; ld pulses load after the last sample edge
  task automatic xfer(input int d, input logic [11:0] w, input int nbits,
                      input bit ld, input logic [11:0] ldw, output logic [11:0] got);
    logic cpol, cpha;
    cpol = logic'(mode[d] / 2);
    cpha = logic'(mode[d] % 2);
    got  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_v[d] = w[bw[d]-1-i];
        tick(6);
        got = {got[10:0], miso_v[d]};
        sclk_v[d] = ~cpol;
        tick(3);
        if (ld && i == nbits - 1) do_load(d, ldw);
        else tick(1);
        tick(2);
        sclk_v[d] = cpol;
      end else begin
        sclk_v[d] = ~cpol;
        mosi_v[d] = w[bw[d]-1-i];
        tick(6);
        got = {got[10:0], miso_v[d]};
        sclk_v[d] = cpol;
        tick(2);
        if (ld && i == nbits - 1) do_load(d, ldw);
        else tick(1);
        tick(3);
      end
    end
  endtask

  task automatic word(input int d, input logic [11:0] w, input bit first,
                      input bit ld, input logic [11:0] ldw);
    logic [11:0] got;
    if ((mode[d] % 2 == 1) && !first) consume(d);
    xfer(d, w, bw[d], ld, ldw, got);
    m_wo[d] = w & msk(d);
    m_br[d]++;
    check("wordout", get_wo(d), m_wo[d]);
    check("br_count_word", brcnt[d], m_br[d]);
    check("miso_word", got & msk(d), cur[d]);
    if (mode[d] % 2 == 0) consume(d);
  endtask

  initial begin
    logic [11:0] junk;
    int          d, nw;
    rst    = 1'b1;
    sclk_v = 3'b010;
    mosi_v = '0;
    ss_v   = '1;
    load_v = '0;
    wordin = '0;
    for (int i = 0; i < 3; i++) begin
      m_buf[i] = '0; m_txe[i] = 1'b1; m_wo[i] = '0; cur[i] = '0;
    end
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_miso", miso_v[i], 0);
      check("rst_wordout", get_wo(i), 0);
      check("rst_br", br_v[i], 0);
      check("rst_txe", txe_v[i], 1);
    end
    tick(6);

    ss_low(0);
    word(0, 12'h09D, 1, 0, 0);
    ss_high(0);

    do_load(0, 12'h095);
    check("txe_after_load", txe_v[0], 0);
    ss_low(0);
    word(0, 12'h0C3, 1, 0, 0);
    ss_high(0);

    do_load(0, 12'h095);
    ss_low(0);
    word(0, 12'h0A6, 1, 1, 12'h080);
    word(0, 12'h05B, 0, 0, 0);
    ss_high(0);

    do_load(1, 12'h3A7);
    ss_low(1);
    word(1, 12'hA5C, 1, 0, 0);
    ss_high(1);
    do_load(2, 12'h6E1);
    ss_low(2);
    word(2, 12'hA5C, 1, 1, 12'h19B);
    word(2, 12'h2F0, 0, 0, 0);
    ss_high(2);

    ss_low(0);
    xfer(0, 12'h0FF, 5, 0, 0, junk);
    ss_high(0);
    ss_low(0);
    word(0, 12'h03C, 1, 0, 0);
    ss_high(0);

    for (int r = 0; r < 30; r++) begin
      d  = int'($urandom_range(0, 2));
      nw = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) do_load(d, 12'($urandom));
      ss_low(d);
      for (int j = 0; j < nw; j++)
        word(d, 12'($urandom), j == 0, 1'($urandom_range(0, 1)), 12'($urandom));
      ss_high(d);
    end

    do_load(0, 12'h05A);
    ss_low(0);
    xfer(0, 12'h0E7, 4, 0, 0, junk);
    do_load(0, 12'h011);
    check("txe_before_rst", txe_v[0], 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_txe[i] = 1'b1; m_wo[i] = '0;
      check("midrst_miso", miso_v[i], 0);
      check("midrst_wordout", get_wo(i), 0);
      check("midrst_br", br_v[i], 0);
      check("midrst_txe", txe_v[i], 1);
    end
    ss_v[0] = 1'b1;
    tick(8);
    ss_low(0);
    word(0, 12'h0F0, 1, 0, 0);
    ss_high(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that oversamples the external SPI pins on the system clock, so all SPI state lives in the `clk` domain. It supports word widths other than 8 and all four SPI modes. It adds a one-entry transmit buffer with an empty flag so words can be streamed back-to-back within one `ss` frame. It is the register-load front end of the DDS: received words go to the tuning/phase register file, and transmitted words carry readback data.

## Interface
- `B`, 8: word width in bits, ≥ 2; all transfers MSB first.
- `MODE`, 0: SPI mode 0..3; CPOL = `MODE[1]` (idle `sclk` level), CPHA = `MODE[0]`.
- `clk` input 1: system clock. One clock; every register is clocked on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sclk` input 1: SPI clock from the master, asynchronous to `clk`.
- `mosi` input 1: serial data in, asynchronous.
- `ss` input 1: slave select, active-low, asynchronous.
- `miso` output 1: serial data out, registered; 0 while `ss` is high (no tristate).
- `wordin` input B: transmit word, captured while `load` is 1.
- `load` input 1: one-cycle strobe that writes `wordin` into the TX buffer.
- `wordout` output B: last complete received word; holds until the next word completes.
- `br` output 1: byte/word-received strobe, high for exactly one `clk` cycle.
- `txe` output 1: TX buffer empty (1 = no pending word).

## Operation
- Input synchronisers:
  - `sclk`, `mosi` and `ss` each pass through 2 flops; a third flop on `sclk` and `ss` provides edge detection.
  - Edges are decoded only from synchronised signals.
- Edge roles:
  - Leading edge = first transition away from CPOL; trailing edge = the return to CPOL.
  - Sample edge is the leading edge if CPHA = 0, the trailing edge if CPHA = 1; the shift edge is the other one.
- Frame start (synchronised `ss` falls):
  - Bit counter is cleared.
  - If `txe` = 0, the TX shift register takes the TX buffer and sets `txe` = 1; otherwise it takes all zeros.
  - CPHA = 0: `miso` is driven with the shift register MSB on the next clk edge.
  - CPHA = 1: `miso` keeps its value until the first leading edge, then presents the MSB.
- Each sample edge (`ss` low):
  - RX shift register takes `{rx[B-2:0], mosi_sync}`.
  - Bit counter increments.
  - On the B-th sample, `wordout` is loaded with the complete word, `br` is 1 for one cycle and the counter wraps to 0.
- Each shift edge (`ss` low): `miso` takes the next bit.
- Word boundary:
  - The first shift edge after a wrap starts the next word and reloads the TX shift register from the TX buffer, or from zeros if `txe` = 1.
  - CPHA = 0: this is the B-th trailing edge.
  - CPHA = 1: this is the next leading edge.
- TX buffer:
  - `load` = 1 writes `wordin` and clears `txe`.
  - `load` on the same clk cycle as a reload: the reload consumes the old buffer contents, then the new word is stored and `txe` = 0.
  - A second `load` before consumption overwrites the buffer.
- `ss` deasserted mid-word:
  - Partial RX word discarded; no `br`; counter cleared; `miso` returns to 0.
  - TX buffer and `wordout` unchanged.
- Edges on `sclk` while `ss` is high are ignored.

## Timing
- Reset values: `miso` = 0, `wordout` = 0, `br` = 0, `txe` = 1, all shift registers, counter and sync flops 0. The sync flops for `sclk` reset to CPOL and those for `ss` reset to 1.
- Reset mid-frame aborts the word, with no `br`. After reset, the slave waits for a fresh `ss` falling edge.
- Latency: a raw pin edge captured at clk edge k acts at clk edge k+2. `wordout`/`br` update at that k+2 edge for the last sample.
- `miso` changes at k+2 of the shift edge.
- Master constraints: `sclk` high and low phases each ≥ 4 `clk` periods. `ss` falling to first `sclk` edge ≥ 4 `clk` periods. `load` must be ≥ 3 `clk` periods before the reloading shift edge to be used for the next word.

## Test plan
- **MODE 0, B = 8, receive.** Stimulus: `ss` low, `mosi` bits 1,0,0,1,1,1,0,1. Response: exactly one `br` pulse, `wordout` = 0x9D, `miso` = 0 throughout (`txe` = 1).
- **MODE 0, transmit.** Stimulus: `load` 0x95 while idle, then an 8-bit frame. Response: `txe` 1→0 after the load and 0→1 at `ss` fall; `miso` bits 1,0,0,1,0,1,0,1, each valid before the sample edge.
- **Back-to-back words.** Stimulus: first word 0x95 preloaded; `load` 0x80 between the 8th sample and the 8th trailing edge; 16 clocks in one frame. Response: `miso` streams 0x95 then 0x80; two `br` pulses.
- **MODE 3 and MODE 1, B = 12.** Stimulus: receive 0xA5C. Response: `wordout` = 0xA5C; the transmitted word is captured correctly on the master's sample edges.
- **Abort.** Stimulus: `ss` high after 5 bits, then a full frame carrying 0x3C. Response: no `br` for the aborted word; the next word is 0x3C, correctly aligned.
- **Reset mid-frame.** Stimulus: `rst` for 1 cycle after bit 4. Response: all outputs return to their reset values next cycle; a following frame 0xF0 is received correctly.
